// File: rtl/rs_pkg.sv
// Shared RS-232 definitions for the rs_tx / rs_rx pair: 8N1 framing, receiver states, bit timing.
// Pure declarations, no logic; receiver flow control is the level dataready/ack handshake.
package rs_pkg;

    localparam int RS_DATA_BITS = 8;
    localparam int RS_STOP_BITS = 1;

    typedef enum logic [2:0] {
        WAIT_IDLE,
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/rs_sync2.sv
// Generic two-flop synchroniser for asynchronous inputs, with a selectable reset value.
// Latency 2 cycles; no handshake, samples every cycle.
module rs_sync2 #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= RST_VAL;
            r_q    <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_q    <= r_meta;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/rs_rx.sv
// 8N1 UART receiver: centre-samples each bit and holds the last good byte behind dataready.
// Delivery 2+HALF+9*CPB+1 cycles after the start edge; never stalls the line, overwrites and flags overrun.
module rs_rx
    import rs_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 115200
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rx,
    input  logic                    ack,
    output logic [RS_DATA_BITS-1:0] data,
    output logic                    dataready,
    output logic                    frame_err,
    output logic                    overrun,
    output logic                    busy
);

    localparam int CPB  = clks_per_bit(CLK_HZ, BAUD);
    localparam int HALF = CPB / 2;
    localparam int CW   = $clog2(CPB);
    localparam int IW   = $clog2(RS_DATA_BITS);

    localparam logic [CW-1:0] C_HALF_LAST = CW'(HALF - 1);
    localparam logic [CW-1:0] C_BIT_LAST  = CW'(CPB - 1);
    localparam logic [IW-1:0] C_IDX_LAST  = IW'(RS_DATA_BITS - 1);

    generate
        if (CPB < 4) begin : g_cpb_too_small
            $error("rs_rx: CLK_HZ/BAUD must be at least 4");
        end
    endgenerate

    logic                    w_rxs;
    rx_state_t               r_state;
    logic [CW-1:0]           r_cnt;
    logic [IW-1:0]           r_idx;
    logic [RS_DATA_BITS-1:0] r_shift;

    rs_sync2 #(
        .WIDTH   (1),
        .RST_VAL (1'b0)
    ) u_rx_sync (
        .i_clk (clk),
        .i_rst (rst),
        .i_d   (rx),
        .o_q   (w_rxs)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= WAIT_IDLE;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_shift   <= '0;
            data      <= '0;
            dataready <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            if (dataready && ack) begin
                dataready <= 1'b0;
            end

            case (r_state)
                WAIT_IDLE: begin
                    if (w_rxs) begin
                        r_state <= IDLE;
                    end
                end

                IDLE: begin
                    if (!w_rxs) begin
                        r_state <= START;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                    end
                end

                START: begin
                    if (r_cnt == C_HALF_LAST) begin
                        r_cnt <= '0;
                        if (!w_rxs) begin
                            r_state <= DATA;
                            r_idx   <= '0;
                        end else begin
                            r_state <= IDLE;
                            busy    <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (r_cnt == C_BIT_LAST) begin
                        r_cnt   <= '0;
                        r_shift <= {w_rxs, r_shift[RS_DATA_BITS-1:1]};
                        r_idx   <= r_idx + 1'b1;
                        if (r_idx == C_IDX_LAST) begin
                            r_state <= STOP;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                STOP: begin
                    // Leave at the stop-bit centre so the next start edge is never missed.
                    if (r_cnt == C_BIT_LAST) begin
                        r_cnt <= '0;
                        busy  <= 1'b0;
                        if (w_rxs) begin
                            data      <= r_shift;
                            dataready <= 1'b1;
                            overrun   <= dataready && !ack;
                            r_state   <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            r_state   <= WAIT_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                default: begin
                    r_state <= WAIT_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rs_rx.sv
// Bench for rs_rx at CPB=10: table-driven frames, hand-written corner sequences, randomized skewed stream.
`timescale 1ns/1ps
module tb_rs_rx;

    localparam int  CLK_HZ = 1_000_000;
    localparam int  BAUD   = 100_000;
    localparam real BIT_NS = 1.0e9 / BAUD;
    localparam int  NRAND  = 40;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       ack;
    logic [7:0] data;
    logic       dataready;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    rs_rx #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .ack       (ack),
        .data      (data),
        .dataready (dataready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #500 clk = ~clk;

    typedef struct {
        logic [7:0] b;
        logic       stop;
        logic       exp_rdy;
        logic       exp_ferr;
    } vec_t;

    vec_t vecs[8];

    int n_cmp = 0;
    int n_bad = 0;
    int n_ferr = 0;
    int n_ovr = 0;
    int n_rise = 0;
    int busy_run = 0;
    int busy_max = 0;
    logic dr_q = 1'b0;

    logic [7:0] exp_data;
    logic [7:0] exp_q[$];
    int lat, lat0, got;
    int r0, f0, o0;

    // Event counters sampled mid-cycle; tests look at their deltas.
    always @(negedge clk) begin
        if (frame_err === 1'b1) n_ferr++;
        if (overrun === 1'b1) n_ovr++;
        if (dataready === 1'b1 && dr_q !== 1'b1) n_rise++;
        dr_q = dataready;
        busy_run = (busy === 1'b1) ? busy_run + 1 : 0;
        if (busy_run > busy_max) busy_max = busy_run;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_rng(input string name, input int act, input int lo, input int hi);
        n_cmp++;
        if (act < lo || act > hi) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input real bit_ns);
        rx = 1'b0;
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            #(bit_ns);
        end
        rx = stop;
        #(bit_ns);
    endtask

    task automatic snap();
        r0 = n_rise;
        f0 = n_ferr;
        o0 = n_ovr;
    endtask

    task automatic do_ack();
        @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, " data"}, data, 8'h00);
        check({tag, " dataready"}, dataready, 1'b0);
        check({tag, " frame_err"}, frame_err, 1'b0);
        check({tag, " overrun"}, overrun, 1'b0);
        check({tag, " busy"}, busy, 1'b0);
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        rx  = 1'b1;
        ack = 1'b0;
        lat0 = 98;
        got = 0;
        vecs[0] = '{8'hA5, 1'b1, 1'b1, 1'b0};
        vecs[1] = '{8'h3C, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{8'h55, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{8'h81, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{8'h00, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{8'hFF, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{8'h5A, 1'b0, 1'b0, 1'b1};
        vecs[7] = '{8'h01, 1'b1, 1'b1, 1'b0};

        cycles(3);
        check_outputs_zero("reset");
        rst = 1'b0;
        cycles(20);
        exp_data = 8'h00;

        // Table-driven single frames, each followed by an ack.
        for (int v = 0; v < 8; v++) begin
            snap();
            lat = 0;
            fork
                send_frame(vecs[v].b, vecs[v].stop, BIT_NS);
                for (int k = 1; k <= 120; k++) begin
                    @(negedge clk);
                    if (dataready === 1'b1 && lat == 0) lat = k;
                end
            join
            if (vecs[v].exp_rdy) begin
                exp_data = vecs[v].b;
                check_rng("vec latency", lat, 97, 99);
                if (v == 0) lat0 = lat;
            end else begin
                cycles(200);
                check("break busy", busy, 1'b0);
                rx = 1'b1;
                cycles(30);
            end
            check("vec rises", n_rise - r0, {31'd0, vecs[v].exp_rdy});
            check("vec frame_err pulses", n_ferr - f0, {31'd0, vecs[v].exp_ferr});
            check("vec overrun pulses", n_ovr - o0, 0);
            check("vec data", data, exp_data);
            check("vec dataready", dataready, vecs[v].exp_rdy);
            do_ack();
            check("vec dataready after ack", dataready, 1'b0);
            check("vec data after ack", data, exp_data);
            cycles(10);
        end

        // Glitch on idle line.
        snap();
        busy_max = 0;
        rx = 1'b0;
        cycles(3);
        rx = 1'b1;
        cycles(30);
        check_rng("glitch busy length", busy_max, 1, 7);
        check("glitch rises", n_rise - r0, 0);
        check("glitch frame_err", n_ferr - f0, 0);
        check("glitch overrun", n_ovr - o0, 0);
        check("glitch busy after", busy, 1'b0);
        send_frame(8'h3C, 1'b1, BIT_NS);
        cycles(10);
        check("post-glitch data", data, 8'h3C);
        check("post-glitch dataready", dataready, 1'b1);
        do_ack();
        cycles(10);

        // Back-to-back with no ack: second delivery overruns.
        snap();
        send_frame(8'h00, 1'b1, BIT_NS);
        send_frame(8'hFF, 1'b1, BIT_NS);
        cycles(10);
        check("b2b rises", n_rise - r0, 1);
        check("b2b overrun pulses", n_ovr - o0, 1);
        check("b2b frame_err", n_ferr - f0, 0);
        check("b2b data", data, 8'hFF);
        check("b2b dataready", dataready, 1'b1);

        // Ack coincides with delivery: delivery wins, no overrun.
        snap();
        fork
            send_frame(8'h96, 1'b1, BIT_NS);
            begin
                cycles(lat0 - 1);
                ack = 1'b1;
                cycles(1);
                ack = 1'b0;
            end
        join
        cycles(10);
        check("ack-on-delivery overrun", n_ovr - o0, 0);
        check("ack-on-delivery dataready", dataready, 1'b1);
        check("ack-on-delivery rises", n_rise - r0, 0);
        check("ack-on-delivery data", data, 8'h96);
        do_ack();
        check("ack-on-delivery cleared", dataready, 1'b0);
        cycles(10);

        // Reset during bit 4 with a byte pending, released while the line is low.
        send_frame(8'h11, 1'b1, BIT_NS);
        cycles(10);
        check("pre-reset dataready", dataready, 1'b1);
        fork
            send_frame(8'h7E, 1'b0, BIT_NS);
            begin
                cycles(55);
                rst = 1'b1;
                #1;
                check_outputs_zero("mid-frame reset");
                cycles(30);
                rst = 1'b0;
                snap();
            end
        join
        cycles(60);
        check("post-reset rises", n_rise - r0, 0);
        check("post-reset frame_err", n_ferr - f0, 0);
        check("post-reset busy", busy, 1'b0);
        rx = 1'b1;
        cycles(20);
        check("post-reset idle rises", n_rise - r0, 0);
        send_frame(8'hC3, 1'b1, BIT_NS);
        cycles(10);
        check("post-reset data", data, 8'hC3);
        check("post-reset delivery", n_rise - r0, 1);
        do_ack();
        cycles(10);

        // Randomized stream with +/-3% bit period and 0..2 idle bits, checked against a byte queue.
        snap();
        exp_q.delete();
        got = 0;
        fork
            begin
                for (int i = 0; i < NRAND; i++) begin
                    logic [7:0] b;
                    real        bn;
                    b  = 8'($urandom_range(0, 255));
                    bn = BIT_NS * (1.0 + ($itor($urandom_range(0, 60)) - 30.0) / 1000.0);
                    exp_q.push_back(b);
                    send_frame(b, 1'b1, bn);
                    rx = 1'b1;
                    #(bn * $urandom_range(0, 2));
                end
            end
            begin
                for (int c = 0; c < NRAND * 140 && got < NRAND; c++) begin
                    @(negedge clk);
                    if (dataready === 1'b1) begin
                        got++;
                        if (exp_q.size() == 0) begin
                            n_cmp++;
                            n_bad++;
                            $display("FAIL rand extra byte: got 0x%0h, expected none", data);
                        end else begin
                            check("rand byte", data, exp_q.pop_front());
                        end
                        cycles($urandom_range(1, 10));
                        ack = 1'b1;
                        cycles(1);
                        ack = 1'b0;
                    end
                end
            end
        join
        cycles(20);
        check("rand byte count", got, NRAND);
        check("rand frame_err", n_ferr - f0, 0);
        check("rand overrun", n_ovr - o0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
